// File: rtl/tbt_mult_host_if.sv
// tbt_mult_host_if: element stream in, multiplier load/result buses, product stream out.
// master = the host (tbt_mult_host); slave = the surrounding environment.
interface tbt_mult_host_if #(
  parameter int FLOATSIZE = 32,
  parameter int LENGTH    = 2
);
  localparam int BUS_W = 2 * LENGTH * FLOATSIZE;

  logic [FLOATSIZE-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_W-1:0]     mult_A;
  logic [BUS_W-1:0]     mult_B;
  logic                 mult_load;
  logic [BUS_W-1:0]     mult_Res;
  logic                 mult_result_ready;
  logic [FLOATSIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 err_timeout;

  modport master (
    input  in_data, in_valid, mult_Res, mult_result_ready, out_ready,
    output in_ready, mult_A, mult_B, mult_load, out_data, out_valid, out_last,
           busy, err_timeout
  );

  modport slave (
    output in_data, in_valid, mult_Res, mult_result_ready, out_ready,
    input  in_ready, mult_A, mult_B, mult_load, out_data, out_valid, out_last,
           busy, err_timeout
  );
endinterface

// File: rtl/tbt_mult_host.sv
// tbt_mult_host: collects A then B (row-major) from an element stream, packs them
// into the multiplier buses, pulses mult_load, waits for mult_result_ready, captures
// the product and streams it out element by element. Data passes through unmodified.
// Optional feature macro: TBT_HOST_TIMEOUT_EN enables the S_WAIT watchdog that sets
// the sticky err_timeout flag after TIMEOUT_CYCLES cycles without a result.
module tbt_mult_host #(
  parameter int FLOATSIZE      = 32,
  parameter int LENGTH         = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           reset,
  tbt_mult_host_if.master bus
);
  localparam int BUS_W = 2 * LENGTH * FLOATSIZE;
  localparam int NELEM = 2 * LENGTH;

  // The packing below assumes a 2x2 matrix (four elements per bus).
  if (LENGTH != 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("tbt_mult_host: only LENGTH=2 and TIMEOUT_CYCLES>=1 are supported");
  end

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [BUS_W-1:0] mult_a_q, mult_b_q, res_q;
  logic             mult_load_q;
  logic             accept;

  // Element 0 sits in the MSBs of a bus, element 3 in the LSBs.
  function automatic logic [FLOATSIZE-1:0] elem_get(input logic [BUS_W-1:0] v,
                                                   input logic [1:0] i);
    return v[(NELEM - 1 - int'(i)) * FLOATSIZE +: FLOATSIZE];
  endfunction

  function automatic logic [BUS_W-1:0] elem_put(input logic [BUS_W-1:0]     v,
                                               input logic [1:0]           i,
                                               input logic [FLOATSIZE-1:0] d);
    logic [BUS_W-1:0] r;
    r = v;
    r[(NELEM - 1 - int'(i)) * FLOATSIZE +: FLOATSIZE] = d;
    return r;
  endfunction

`ifdef TBT_HOST_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt_q;
  logic              timeout_hit;
  logic              err_q;
`endif

  assign bus.in_ready = reset && ((state_q == S_LOAD_A) || (state_q == S_LOAD_B));
  assign accept       = bus.in_valid && bus.in_ready;

  // Next-state and index logic for the load / start / wait / drain sequence
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef TBT_HOST_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A result arriving on the limit cycle takes priority over the watchdog.
        if (bus.mult_result_ready) begin
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end
`ifdef TBT_HOST_TIMEOUT_EN
        else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          idx_d       = 2'd0;
          state_d     = S_LOAD_A;
        end
`endif
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = S_LOAD_A;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        idx_d   = 2'd0;
        state_d = S_LOAD_A;
      end
    endcase
  end

  // State, element index and the registered one-cycle start pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_LOAD_A;
      idx_q       <= 2'd0;
      mult_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mult_load_q <= (state_d == S_START);
    end
  end

  // Operand packing and product capture; operands only change in the load states
  always_ff @(posedge clk) begin
    if (!reset) begin
      mult_a_q <= '0;
      mult_b_q <= '0;
      res_q    <= '0;
    end else begin
      if (accept && (state_q == S_LOAD_A)) mult_a_q <= elem_put(mult_a_q, idx_q, bus.in_data);
      if (accept && (state_q == S_LOAD_B)) mult_b_q <= elem_put(mult_b_q, idx_q, bus.in_data);
      if ((state_q == S_WAIT) && bus.mult_result_ready) res_q <= bus.mult_Res;
    end
  end

`ifdef TBT_HOST_TIMEOUT_EN
  // Wait-cycle counter (zero outside S_WAIT) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_WAIT) tcnt_q <= tcnt_q + TCNT_W'(1);
      else                   tcnt_q <= '0;
      if (timeout_hit)       err_q  <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.mult_A    = mult_a_q;
  assign bus.mult_B    = mult_b_q;
  assign bus.mult_load = mult_load_q;
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_data  = elem_get(res_q, idx_q);
  assign bus.out_last  = (state_q == S_DRAIN) && (idx_q == 2'd3);
  assign bus.busy      = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_tbt_mult_host.sv
// Directed bench for tbt_mult_host with a behavioural multiplier of programmable
// latency (m_lat cycles after mult_load; 0 means never respond).
`timescale 1ns/1ps
module tb_tbt_mult_host;
  localparam int FS = 32;
  localparam int LEN = 2;
  localparam int BW = 128;
  localparam int TO = 16;

  localparam logic [BW-1:0] A1   = 128'h3F800000_40000000_40400000_40800000;
  localparam logic [BW-1:0] ID   = 128'h3F800000_00000000_00000000_3F800000;
  localparam logic [BW-1:0] A3   = 128'h40A00000_40C00000_40E00000_41000000;
  localparam logic [BW-1:0] B3   = 128'h3F000000_3F000000_3F000000_3F000000;
  localparam logic [BW-1:0] R3   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [BW-1:0] A4   = 128'hC0000000_3E800000_7F800000_FF800000;
  localparam logic [BW-1:0] B4   = 128'h00000001_80000000_7FC00000_00800000;
  localparam logic [BW-1:0] R4   = 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000;
  localparam logic [BW-1:0] JUNK = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [BW-1:0] A5   = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [BW-1:0] R5   = 128'hCAFEF00D_12345678_9ABCDEF0_0F0F0F0F;
  localparam logic [BW-1:0] A6   = 128'h41100000_41200000_41300000_41400000;
  localparam logic [BW-1:0] B6   = 128'hBF800000_3F800000_BF800000_3F800000;
  localparam logic [BW-1:0] R6   = 128'h80000001_7FFFFFFE_00FF00FF_FF00FF00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tbt_mult_host_if #(.FLOATSIZE(FS), .LENGTH(LEN)) bus ();

  tbt_mult_host #(.FLOATSIZE(FS), .LENGTH(LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] res_val = '0;
  logic stray = 1'b0;
  logic model_rdy = 1'b0;
  int m_lat = 20;
  int m_cnt = 0;

  assign bus.mult_Res = res_val;
  assign bus.mult_result_ready = model_rdy | stray;

  // multiplier model: one-cycle ready pulse m_lat cycles after mult_load
  always @(posedge clk) begin
    if (!reset) begin
      m_cnt <= 0;
      model_rdy <= 1'b0;
    end else begin
      model_rdy <= 1'b0;
      if (bus.mult_load && m_lat > 0) m_cnt <= m_lat;
      else if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else if (m_cnt == 1) begin
        m_cnt <= 0;
        model_rdy <= 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [FS-1:0] d);
    int n;
    n = 0;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_ready_wait", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bus(input logic [BW-1:0] v, input int gap);
    for (int k = 0; k < 4; k++) begin
      send(v[BW-1-FS*k -: FS]);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, 128'(bus.out_valid), 128'd1);
  endtask

  // expects out_ready=1 and the first beat currently presented
  task automatic drain_all(input string tag, input logic [BW-1:0] exp);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_v%0d", tag, k), 128'(bus.out_valid), 128'd1);
      chk($sformatf("%s_d%0d", tag, k), 128'(bus.out_data), 128'(exp[BW-1-FS*k -: FS]));
      chk($sformatf("%s_l%0d", tag, k), 128'(bus.out_last), 128'(k == 3));
      chk($sformatf("%s_ir%0d", tag, k), 128'(bus.in_ready), 128'd0);
      tick();
    end
    chk({tag, "_done_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_done_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_done_inready"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic [FS-1:0] got [4];
    logic [FS-1:0] prev_data;
    logic prev_last;
    logic stalled_prev;
    bit pat [6];
    int acc, lasts, last_at, unstable, bad, n;

    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_mult_A", bus.mult_A, 128'd0);
    chk("rst_mult_B", bus.mult_B, 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_mult_load", 128'(bus.mult_load), 128'd0);
    chk("rst_err", 128'(bus.err_timeout), 128'd0);
    reset = 1'b1;
    tick();
    chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

    // 1: back-to-back load of A=[1,2;3,4], B=I
    res_val = A1;
    m_lat = 20;
    send_bus(A1, 0);
    send_bus(ID, 0);
    chk("t1_mult_A", bus.mult_A, A1);
    chk("t1_mult_B", bus.mult_B, ID);
    chk("t1_load_hi", 128'(bus.mult_load), 128'd1);
    chk("t1_busy", 128'(bus.busy), 128'd1);
    chk("t1_in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    chk("t1_load_lo", 128'(bus.mult_load), 128'd0);

    // 2: result after 20 cycles, drained with out_ready held high
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.mult_result_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t2_rdy_seen", 128'(bus.mult_result_ready), 128'd1);
    chk("t2_pre_valid", 128'(bus.out_valid), 128'd0);
    tick();
    drain_all("t2", A1);

    // 3: out_ready pattern 1,0,0,1,0,1 repeating
    res_val = R3;
    m_lat = 3;
    bus.out_ready = 1'b0;
    send_bus(A3, 0);
    send_bus(B3, 0);
    wait_valid("t3");
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    acc = 0;
    lasts = 0;
    last_at = -1;
    unstable = 0;
    stalled_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      bus.out_ready = pat[c % 6];
      if (stalled_prev && (bus.out_data !== prev_data || bus.out_last !== prev_last)) unstable++;
      if (bus.out_valid && bus.out_ready) begin
        got[acc] = bus.out_data;
        if (bus.out_last) begin
          lasts++;
          last_at = acc;
        end
        acc++;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      tick();
    end
    chk("t3_beats", 128'(acc), 128'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_d%0d", k), 128'(got[k]), 128'(R3[BW-1-FS*k -: FS]));
    chk("t3_last_count", 128'(lasts), 128'd1);
    chk("t3_last_pos", 128'(last_at), 128'd3);
    chk("t3_stable", 128'(unstable), 128'd0);
    chk("t3_end_valid", 128'(bus.out_valid), 128'd0);

    // 4: gapped input, stray result pulse in S_LOAD_B, in_valid pressure in S_WAIT
    bus.out_ready = 1'b0;
    m_lat = 6;
    send(A4[127:96]);
    tick();
    send(A4[95:64]);
    send(A4[63:32]);
    tick();
    tick();
    send(A4[31:0]);
    tick();
    send(B4[127:96]);
    res_val = JUNK;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    res_val = R4;
    chk("t4_stray_inready", 128'(bus.in_ready), 128'd1);
    chk("t4_stray_busy", 128'(bus.busy), 128'd0);
    chk("t4_stray_valid", 128'(bus.out_valid), 128'd0);
    tick();
    send(B4[95:64]);
    tick();
    tick();
    tick();
    send(B4[63:32]);
    send(B4[31:0]);
    bus.in_data = 32'hBAD0BAD0;
    bus.in_valid = 1'b1;
    bad = 0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b0) bad++;
      if (bus.mult_A !== A4 || bus.mult_B !== B4) bad++;
      tick();
      n++;
    end
    chk("t4_wait_hold", 128'(bad), 128'd0);
    chk("t4_valid_seen", 128'(bus.out_valid), 128'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain_all("t4", R4);
    chk("t4_keep_A", bus.mult_A, A4);
    chk("t4_keep_B", bus.mult_B, B4);

    // 5: reset during the second drain beat, then a clean transaction
    res_val = R5;
    m_lat = 4;
    send_bus(A5, 0);
    send_bus(A3, 1);
    wait_valid("t5");
    chk("t5_beat0", 128'(bus.out_data), 128'(R5[127:96]));
    tick();
    chk("t5_beat1", 128'(bus.out_data), 128'(R5[95:64]));
    reset = 1'b0;
    tick();
    chk("t5_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("t5_rst_busy", 128'(bus.busy), 128'd0);
    chk("t5_rst_A", bus.mult_A, 128'd0);
    chk("t5_rst_B", bus.mult_B, 128'd0);
    chk("t5_rst_inready", 128'(bus.in_ready), 128'd0);
    reset = 1'b1;
    tick();
    res_val = R6;
    m_lat = 7;
    send_bus(A6, 0);
    send_bus(B6, 0);
    chk("t5_A6", bus.mult_A, A6);
    chk("t5_B6", bus.mult_B, B6);
    wait_valid("t5b");
    drain_all("t5b", R6);

`ifdef TBT_HOST_TIMEOUT_EN
    // 6: model never answers; watchdog fires after TO wait cycles
    m_lat = 0;
    send_bus(A1, 0);
    send_bus(ID, 0);
    for (int k = 0; k < TO; k++) tick();
    chk("t6_err_before", 128'(bus.err_timeout), 128'd0);
    chk("t6_busy_before", 128'(bus.busy), 128'd1);
    tick();
    chk("t6_err_set", 128'(bus.err_timeout), 128'd1);
    chk("t6_inready", 128'(bus.in_ready), 128'd1);
    chk("t6_busy_after", 128'(bus.busy), 128'd0);
    tick();
    tick();
    chk("t6_err_sticky", 128'(bus.err_timeout), 128'd1);
    res_val = A1;
    m_lat = 3;
    bus.out_ready = 1'b1;
    send_bus(A1, 0);
    send_bus(ID, 0);
    wait_valid("t6b");
    drain_all("t6b", A1);
    chk("t6_err_still", 128'(bus.err_timeout), 128'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_err_cleared", 128'(bus.err_timeout), 128'd0);
`else
    chk("no_timeout_err", 128'(bus.err_timeout), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
